// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/subtract unit: one full-adder cell reused over WIDTH
// cycles, with a ready/start request side and a valid/ack result side.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i, ready_o  request handshake (accepted while ready_o=1)
//   op_i              0=ADD src1+src2, 1=SUB src1-src2 (sampled at accept)
//   src1_i, src2_i    WIDTH-bit operands (sampled at accept)
//   busy_o            serial computation in progress
//   valid_o, ack_i    result handshake (held until ack_i)
//   result_o          WIDTH-bit sum/difference
//   carryOut_o        carry out of MSB (SUB: 1 = no borrow)
//   overflow_o        signed overflow
//   zero_o            result_o == 0
//   abort_i           only with SERIAL_ALU_SEQUENCER_ABORT_EN defined:
//                     cancels a running operation
module serial_alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carryOut_o,
    output logic             overflow_o,
    output logic             zero_o
`ifdef SERIAL_ALU_SEQUENCER_ABORT_EN
    ,
    input  logic             abort_i
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_sum;
    logic             w_co;
    logic             w_last;
    logic             w_abort;
    logic [WIDTH-1:0] w_sh_nxt;

`ifdef SERIAL_ALU_SEQUENCER_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    // The single shared full-adder cell.
    assign w_sum = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_co  = (r_a[0] & r_b[0]) |
                   (r_a[0] & r_carry) |
                   (r_b[0] & r_carry);

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at [0].
    assign w_sh_nxt = {w_sum, r_sh[WIDTH-1:1]};
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        valid_o     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                // Abort takes priority over completing on the last bit.
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Visible result/flags live in separate registers so an aborted or
    // in-flight operation never disturbs the last delivered result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a     <= src1_i;
                        // SUB is a + ~b + 1; the +1 is the initial carry.
                        r_b     <= op_i ? ~src2_i : src2_i;
                        r_carry <= op_i;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_cnt <= '0;
                    end else begin
                        r_a     <= r_a >> 1;
                        r_b     <= r_b >> 1;
                        r_sh    <= w_sh_nxt;
                        r_carry <= w_co;
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_res  <= w_sh_nxt;
                            r_cout <= w_co;
                            // r_carry here is the carry into the MSB.
                            r_ovf  <= r_carry ^ w_co;
                            r_zero <= (w_sh_nxt == '0);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o   = r_res;
    assign carryOut_o = r_cout;
    assign overflow_o = r_ovf;
    assign zero_o     = r_zero;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Testbench for serial_alu_sequencer (WIDTH=8): vector table, scoreboard
// queue, and hand-written sequences for hold, reset and abort cases.
module tb_serial_alu_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         ready;
    logic         op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         valid;
    logic         ack;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         abort;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ready_o    (ready),
        .op_i       (op),
        .src1_i     (src1),
        .src2_i     (src2),
        .busy_o     (busy),
        .valid_o    (valid),
        .ack_i      (ack),
        .result_o   (res),
        .carryOut_o (cout),
        .overflow_o (ovf),
        .zero_o     (zero)
`ifdef SERIAL_ALU_SEQUENCER_ABORT_EN
        ,
        .abort_i    (abort)
`endif
    );

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Independent reference: widened add plus sign-rule overflow.
    function automatic vec_t model(input logic o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        vec_t      v;
        logic [W:0] f;
        f = {1'b0, a} + {1'b0, (o ? ~b : b)} + {{W{1'b0}}, o};
        v.op = o;
        v.a  = a;
        v.b  = b;
        v.r  = f[W-1:0];
        v.c  = f[W];
        if (o)
            v.v = (a[W-1] != b[W-1]) && (v.r[W-1] != a[W-1]);
        else
            v.v = (a[W-1] == b[W-1]) && (v.r[W-1] != a[W-1]);
        v.z = (v.r == '0);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst)
            chk("onehot", 64'($onehot({ready, busy, valid})), 64'd1);
    end

    task automatic do_accept(input logic o, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        int n;
        n = 0;
        while (!ready && n < 30) begin
            tick;
            n++;
        end
        chk("ready_wait", 64'(ready), 64'd1);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        tick;
        start = 1'b0;
        src1  = W'($urandom);
        src2  = W'($urandom);
        op    = 1'($urandom);
    endtask

    task automatic wait_valid(input int lat0, output int lat);
        lat = lat0;
        while (!valid && lat < 30) begin
            tick;
            lat++;
        end
    endtask

    task automatic compare_out(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            last = e;
            chk({tag, "_res"},  64'(res),  64'(e.r));
            chk({tag, "_cout"}, 64'(cout), 64'(e.c));
            chk({tag, "_ovf"},  64'(ovf),  64'(e.v));
            chk({tag, "_zero"}, 64'(zero), 64'(e.z));
        end
    endtask

    task automatic do_ack;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("ack_ready", 64'(ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        do_accept(v.op, v.a, v.b);
        sb.push_back(v);
        wait_valid(0, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(W));
        compare_out(tag);
        do_ack();
    endtask

    vec_t tbl[6];

    initial begin
        int   lat;
        logic seen;
        vec_t v;

        tbl[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        src1  = '0;
        src2  = '0;
        ack   = 1'b0;
        abort = 1'b0;
        tick;
        tick;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_res",   64'(res),   64'd0);
        chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v = model(1'($urandom), W'($urandom), W'($urandom));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Requests during RUN/DONE and ack during RUN are ignored.
        do_accept(1'b0, 8'h12, 8'h34);
        sb.push_back(model(1'b0, 8'h12, 8'h34));
        tick;
        tick;
        start = 1'b1;
        op    = 1'b1;
        src1  = 8'hFF;
        src2  = 8'hFF;
        ack   = 1'b1;
        tick;
        start = 1'b0;
        ack   = 1'b0;
        chk("run_busy", 64'(busy), 64'd1);
        wait_valid(3, lat);
        chk("hold_lat", 64'(lat), 64'(W));
        compare_out("hold");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                src1  = 8'h00;
                src2  = 8'h00;
            end
            tick;
            start = 1'b0;
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_res",   64'(res),   64'h46);
        end
        do_ack();
        run_vec(model(1'b0, 8'h01, 8'h01), "imm");

        // Asynchronous reset in the 4th RUN cycle, away from any edge.
        do_accept(1'b0, 8'h55, 8'h11);
        tick;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_busy",  64'(busy),  64'd0);
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_res",   64'(res),   64'd0);
        chk("arst_flags", 64'({cout, ovf, zero}), 64'd0);
        tick;
        tick;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (valid) seen = 1'b1;
        end
        chk("arst_novalid", 64'(seen), 64'd0);
        chk("arst_ready2",  64'(ready), 64'd1);
        run_vec(tbl[5], "post_rst");

`ifdef SERIAL_ALU_SEQUENCER_ABORT_EN
        do_accept(1'b0, 8'hAA, 8'h0F);
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("ab3_ready", 64'(ready), 64'd1);
        chk("ab3_res",   64'(res),   64'(last.r));
        chk("ab3_flags", 64'({cout, ovf, zero}),
            64'({last.c, last.v, last.z}));
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (valid) seen = 1'b1;
        end
        chk("ab3_novalid", 64'(seen), 64'd0);

        do_accept(1'b1, 8'h01, 8'h02);
        for (int i = 0; i < W - 1; i++)
            tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abl_ready", 64'(ready), 64'd1);
        chk("abl_valid", 64'(valid), 64'd0);
        chk("abl_res",   64'(res),   64'(last.r));
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (valid) seen = 1'b1;
        end
        chk("abl_novalid", 64'(seen), 64'd0);
        run_vec(tbl[0], "post_abort");
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
